// File: rtl/delay_pulse_rx.sv
// rtl/delay_pulse_rx.sv - receive-side period checker for the periodic delay/pulse generator output
// Optional error tally: define DELAY_PULSE_RX_STATS_EN to enable err_count, otherwise it is tied to 0.
module delay_pulse_rx #(
  parameter int N        = 50000,
  parameter int CBITS    = 16,
  parameter int TOL      = 2,
  parameter int LOCK_CNT = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sig_in,
  output logic             locked,
  output logic             pulse_ok,
  output logic             early_err,
  output logic             late_err,
  output logic [CBITS-1:0] period_out,
  output logic [7:0]       err_count
);

  localparam int GBITS = (LOCK_CNT < 2) ? 1 : $clog2(LOCK_CNT + 1);
  localparam logic [CBITS-1:0] P_LO     = CBITS'(N + 1 - TOL);
  localparam logic [CBITS-1:0] P_HI     = CBITS'(N + 1 + TOL);
  localparam logic [GBITS-1:0] LOCK_TGT = GBITS'(LOCK_CNT);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SYNC,
    ST_LOCKED
  } state_t;

  state_t             state_q, state_d;
  logic               sig_q;
  logic [CBITS-1:0]   gap_q, gap_d;
  logic [GBITS-1:0]   good_cnt_q, good_cnt_d;
  logic               locked_q, locked_d;
  logic               pulse_ok_q, pulse_ok_d;
  logic               early_err_q, early_err_d;
  logic               late_err_q, late_err_d;
  logic [CBITS-1:0]   period_q, period_d;

  logic               rise;
  logic [CBITS-1:0]   meas;
  logic               is_good;
  logic               is_early;
  logic               timeout;
  logic [GBITS-1:0]   good_inc;

  // Edge detect, gap measurement, classification and next-state/output decode
  always_comb begin
    rise     = sig_in & ~sig_q;
    // meas doubles as the saturating increment of the gap counter
    meas     = (&gap_q) ? gap_q : gap_q + 1'b1;
    is_good  = (meas >= P_LO) && (meas <= P_HI);
    is_early = (meas < P_LO);
    // an edge landing on the timeout cycle wins and is judged as a late edge
    timeout  = (state_q != ST_IDLE) && !rise && (gap_q == P_HI);
    good_inc = good_cnt_q + 1'b1;

    gap_d       = rise ? '0 : meas;
    state_d     = state_q;
    good_cnt_d  = good_cnt_q;
    locked_d    = locked_q;
    pulse_ok_d  = 1'b0;
    early_err_d = 1'b0;
    late_err_d  = 1'b0;
    period_d    = period_q;

    case (state_q)
      ST_IDLE: begin
        locked_d = 1'b0;
        if (rise) begin
          good_cnt_d = '0;
          state_d    = ST_SYNC;
        end
      end
      ST_SYNC, ST_LOCKED: begin
        if (rise) begin
          period_d = meas;
          if (is_good) begin
            pulse_ok_d = 1'b1;
            if (state_q == ST_SYNC) begin
              good_cnt_d = good_inc;
              if (good_inc == LOCK_TGT) begin
                state_d  = ST_LOCKED;
                locked_d = 1'b1;
              end
            end
          end else begin
            early_err_d = is_early;
            late_err_d  = ~is_early;
            good_cnt_d  = '0;
            locked_d    = 1'b0;
            state_d     = ST_SYNC;
          end
        end else if (timeout) begin
          late_err_d = 1'b1;
          locked_d   = 1'b0;
          state_d    = ST_IDLE;
        end
      end
      default: begin
        state_d  = ST_IDLE;
        locked_d = 1'b0;
      end
    endcase
  end

  // State, counters and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      sig_q       <= 1'b0;
      gap_q       <= '0;
      good_cnt_q  <= '0;
      locked_q    <= 1'b0;
      pulse_ok_q  <= 1'b0;
      early_err_q <= 1'b0;
      late_err_q  <= 1'b0;
      period_q    <= '0;
    end else begin
      state_q     <= state_d;
      sig_q       <= sig_in;
      gap_q       <= gap_d;
      good_cnt_q  <= good_cnt_d;
      locked_q    <= locked_d;
      pulse_ok_q  <= pulse_ok_d;
      early_err_q <= early_err_d;
      late_err_q  <= late_err_d;
      period_q    <= period_d;
    end
  end

  assign locked     = locked_q;
  assign pulse_ok   = pulse_ok_q;
  assign early_err  = early_err_q;
  assign late_err   = late_err_q;
  assign period_out = period_q;

`ifdef DELAY_PULSE_RX_STATS_EN
  logic [7:0] err_count_q, err_count_d;

  // Saturating tally of early/late strobes, updated alongside the strobe
  always_comb begin
    err_count_d = err_count_q;
    if ((early_err_d || late_err_d) && (err_count_q != 8'hFF)) begin
      err_count_d = err_count_q + 8'd1;
    end
  end

  // Error tally register
  always_ff @(posedge clk) begin
    if (rst) begin
      err_count_q <= 8'd0;
    end else begin
      err_count_q <= err_count_d;
    end
  end

  assign err_count = err_count_q;
`else
  assign err_count = 8'd0;
`endif

endmodule

// File: tb/tb_delay_pulse_rx.sv
// tb/tb_delay_pulse_rx.sv - self-checking bench for delay_pulse_rx
module tb_delay_pulse_rx;

  localparam int N        = 10;
  localparam int CBITS    = 8;
  localparam int TOL      = 1;
  localparam int LOCK_CNT = 3;
  localparam int P        = N + 1;
  localparam int MAXC     = 700;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             sig_in = 1'b0;
  logic             locked, pulse_ok, early_err, late_err;
  logic [CBITS-1:0] period_out;
  logic [7:0]       err_count;

  always #5 clk = ~clk;

  delay_pulse_rx #(.N(N), .CBITS(CBITS), .TOL(TOL), .LOCK_CNT(LOCK_CNT)) dut (
    .clk(clk), .rst(rst), .sig_in(sig_in),
    .locked(locked), .pulse_ok(pulse_ok), .early_err(early_err), .late_err(late_err),
    .period_out(period_out), .err_count(err_count)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int scen     = -1;
  int cur_c    = -1;

  bit pat[MAXC];
  bit rpat[MAXC];

  typedef struct { int s; int c; int what; int v; } lit_t;
  lit_t lits[$];

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s scen=%0d cycle=%0d got=%0d expected=%0d", name, scen, cur_c, act, exp);
    end
  endtask

  // Timestamp-based model: a pulse's period is the cycle distance to the previous accepted edge.
  int  mcyc, anchor, good, mode;   // mode: 0 idle, 1 syncing, 2 locked
  int  m;
  bit  prev_in, rising, mvalid = 1'b0;
  int  e_locked, e_ok, e_early, e_late, e_period, e_err;

  always @(posedge clk) begin
    if (rst) begin
      mcyc = 0; anchor = 0; good = 0; mode = 0; prev_in = 1'b0;
      e_locked = 0; e_ok = 0; e_early = 0; e_late = 0; e_period = 0; e_err = 0;
      mvalid = 1'b1;
    end else begin
      rising  = sig_in && !prev_in;
      prev_in = sig_in;
      e_ok = 0; e_early = 0; e_late = 0;
      if (rising) begin
        if (mode == 0) begin
          anchor = mcyc; good = 0; mode = 1;
        end else begin
          m = mcyc - anchor;
          if (m > 255) m = 255;
          anchor   = mcyc;
          e_period = m;
          if (m >= P - TOL && m <= P + TOL) begin
            e_ok = 1;
            if (mode == 1) begin
              good++;
              if (good == LOCK_CNT) begin mode = 2; e_locked = 1; end
            end
          end else begin
            if (m < P - TOL) e_early = 1; else e_late = 1;
            good = 0; mode = 1; e_locked = 0;
          end
        end
      end else if (mode != 0 && mcyc - anchor == P + TOL + 1) begin
        e_late = 1; e_locked = 0; mode = 0;
      end
`ifdef DELAY_PULSE_RX_STATS_EN
      if ((e_early != 0 || e_late != 0) && e_err < 255) e_err++;
`endif
      mcyc++;
    end
  end

  // Cycle-by-cycle comparison against the model
  always @(negedge clk) begin
    if (mvalid) begin
      chk("locked",     int'(locked),     e_locked);
      chk("pulse_ok",   int'(pulse_ok),   e_ok);
      chk("early_err",  int'(early_err),  e_early);
      chk("late_err",   int'(late_err),   e_late);
      chk("period_out", int'(period_out), e_period);
      chk("err_count",  int'(err_count),  e_err);
    end
  end

  function automatic int pick(input int w);
    case (w)
      0: return int'(locked);
      1: return int'(pulse_ok);
      2: return int'(early_err);
      3: return int'(late_err);
      4: return int'(period_out);
      default: return int'(err_count);
    endcase
  endfunction

  task automatic lit(input int s, input int c, input int w, input int v);
    lit_t l;
    l.s = s; l.c = c; l.what = w; l.v = v;
    lits.push_back(l);
  endtask

  task automatic clr();
    for (int i = 0; i < MAXC; i++) begin pat[i] = 1'b0; rpat[i] = 1'b0; end
  endtask

  task automatic pulse(input int c, input int w);
    for (int i = 0; i < w; i++) pat[c + i] = 1'b1;
  endtask

  // Reset for 3 cycles (sig_in at its cycle-0 level), then play the pattern and check literals
  task automatic run(input int s, input int len);
    scen  = s;
    cur_c = -1;
    rst    = 1'b1;
    sig_in = pat[0];
    repeat (3) @(posedge clk);
    #1;
    for (int c = 0; c < len; c++) begin
      rst    = rpat[c];
      sig_in = pat[c];
      cur_c  = c;
      @(negedge clk);
      foreach (lits[i]) begin
        if (lits[i].s == s && lits[i].c == c) chk($sformatf("literal_w%0d", lits[i].what), pick(lits[i].what), lits[i].v);
      end
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    // what: 0 locked, 1 pulse_ok, 2 early_err, 3 late_err, 4 period_out, 5 err_count
    for (int w = 0; w < 6; w++) lit(0, 0, w, 0);
    lit(1, 3, 1, 0);  lit(1, 13, 1, 0); lit(1, 14, 1, 1); lit(1, 35, 0, 0);
    lit(1, 36, 0, 1); lit(1, 36, 4, 11); lit(1, 36, 1, 1);
    lit(2, 46, 1, 1); lit(2, 46, 4, 10); lit(2, 58, 1, 1); lit(2, 58, 4, 12);
    lit(2, 66, 0, 1); lit(2, 67, 2, 1); lit(2, 67, 4, 9); lit(2, 67, 0, 0);
    lit(2, 99, 0, 0); lit(2, 100, 0, 1);
    lit(3, 48, 3, 0); lit(3, 48, 0, 1); lit(3, 49, 3, 1); lit(3, 49, 0, 0);
    lit(3, 60, 3, 0); lit(3, 71, 1, 0); lit(3, 82, 1, 1); lit(3, 82, 0, 0);
    lit(4, 4, 1, 0);  lit(4, 14, 1, 1); lit(4, 35, 0, 0); lit(4, 36, 0, 1);
    lit(5, 16, 3, 1); lit(5, 16, 4, 13); lit(5, 28, 1, 1); lit(5, 37, 2, 1);
    lit(5, 37, 4, 9); lit(5, 47, 1, 1); lit(5, 47, 4, 10);
`ifdef DELAY_PULSE_RX_STATS_EN
    lit(6, 513, 5, 255); lit(6, 609, 5, 255); lit(5, 38, 5, 2);
`else
    lit(6, 513, 5, 0);   lit(6, 609, 5, 0);   lit(5, 38, 5, 0);
`endif
    lit(7, 12, 1, 1); lit(7, 12, 4, 11);
    lit(8, 14, 1, 1); lit(8, 25, 1, 0); lit(8, 25, 4, 0);

    // 0: reset only
    clr();
    run(0, 5);
    // 1: lock
    clr();
    pulse(2, 1); pulse(13, 1); pulse(24, 1); pulse(35, 1);
    run(1, 40);
    // 2: tolerance window while locked, then relock
    clr();
    pulse(2, 1); pulse(13, 1); pulse(24, 1); pulse(35, 1);
    pulse(45, 1); pulse(57, 1); pulse(66, 1);
    pulse(77, 1); pulse(88, 1); pulse(99, 1);
    run(2, 105);
    // 3: missing pulse timeout, then re-anchor from idle
    clr();
    pulse(2, 1); pulse(13, 1); pulse(24, 1); pulse(35, 1);
    pulse(70, 1); pulse(81, 1);
    run(3, 90);
    // 4: held high levels count as single edges
    clr();
    pulse(2, 5); pulse(13, 5); pulse(24, 5); pulse(35, 5);
    run(4, 40);
    // 5: edge on the timeout cycle is a late edge; early and P-TOL boundary in sync
    clr();
    pulse(2, 1); pulse(15, 1); pulse(27, 1); pulse(36, 1); pulse(46, 1);
    run(5, 50);
    // 6: sustained early pulses to saturate the error tally
    clr();
    for (int k = 0; k < 302; k++) pulse(2 + 2 * k, 1);
    run(6, 610);
    // 7: sig_in high through reset gives an edge in cycle 0
    clr();
    pulse(0, 4); pulse(11, 1);
    run(7, 15);
    // 8: reset mid-operation suppresses the pending strobe
    clr();
    pulse(2, 1); pulse(13, 1); pulse(24, 1);
    rpat[24] = 1'b1;
    run(8, 30);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/delay_pulse_rx.md
Name: delay_pulse_rx

Overview:
- Receive-side checker for the periodic single-cycle pulse produced by the team's N-cycle delay/pulse generator.
- Measures the gap between successive rising edges of sig_in and compares it with the expected period P = N+1 within ±TOL cycles.
- Reports early and late pulses, and asserts locked after LOCK_CNT consecutive in-window periods.
- Sits on the consumer side of the pulse link; drives supervision/status logic.

Parameters:
- N, 50000, generator terminal count; expected period P = N+1 clk cycles.
- CBITS, 16, gap counter and period_out width; must satisfy 2^CBITS-1 > N+1+TOL.
- TOL, 2, accepted deviation in cycles from P, symmetric.
- LOCK_CNT, 3, consecutive good periods required to assert locked; ≥1.

Ports:
- clk  input  1  clock, all logic on posedge
- rst  input  1  synchronous, active-high reset
- sig_in  input  1  pulse from generator; rising edges only are used
- locked  output  1  period tracking established
- pulse_ok  output  1  one-cycle strobe: an in-window pulse was received
- early_err  output  1  one-cycle strobe: pulse arrived with gap M < P-TOL
- late_err  output  1  one-cycle strobe: no pulse by gap P+TOL, or pulse with M > P+TOL
- period_out  output  CBITS  last measured gap M, saturating
- err_count  output  8  saturating error tally (see Optional Feature)

Behaviour:
- Reset: rst is synchronous, active-high; clock is clk. All outputs 0, gap=0, good_cnt=0, sig_q=0, state IDLE. A sig_in held high through reset yields an edge in the first cycle after reset.
- Edge detection: edge = sig_in & ~sig_q; sig_q <= sig_in every cycle. Multi-cycle highs count as one pulse.
- Gap counter: cleared to 0 on an edge cycle; otherwise increments, saturating at all-ones. Measured gap at an edge: M = gap+1, saturating. Pulses P cycles apart give M = P.
- Outputs are registered. Every strobe and every locked or period_out change is visible the cycle after the triggering edge or timeout. Strobes last exactly one cycle.
- Good: P-TOL ≤ M ≤ P+TOL. Early: M < P-TOL. Late edge: M > P+TOL.
- Timeout: in SYNC/LOCKED, gap == P+TOL with no edge in that cycle. Fires once per missing interval; the counter keeps running, saturating.
- IDLE: locked=0. First edge anchors: gap cleared, good_cnt=0, go SYNC. No strobe; period_out unchanged.
- SYNC, good edge: pulse_ok, period_out=M, good_cnt++. When good_cnt reaches LOCK_CNT, go LOCKED and locked=1.
- SYNC, early or late edge: matching strobe, period_out=M, good_cnt=0, stay SYNC (re-anchored on this edge).
- SYNC, timeout: late_err, go IDLE.
- LOCKED, good edge: pulse_ok, period_out=M, stay.
- LOCKED, early or late edge: matching strobe, period_out=M, locked=0, good_cnt=0, go SYNC.
- LOCKED, timeout: late_err, locked=0, go IDLE.
- Edge in the same cycle as gap == P+TOL: the edge wins. It is evaluated as a late edge (M = P+TOL+1), not a timeout.
- rst mid-operation: immediate full clear at that edge; any pending strobe is suppressed.

Optional Feature:
- Macro DELAY_PULSE_RX_STATS_EN.
- Defined: err_count increments by 1 on each early_err or late_err strobe, registered with the strobe, and saturates at 255. Cleared only by rst.
- Undefined: no counter logic; err_count tied to 0. Port list is unchanged.

Test Plan:
(All scenarios use N=10 so P=11, TOL=1, LOCK_CNT=3, CBITS=8; cycle 0 = first cycle after rst deasserts.)
- Reset: rst high 3 cycles with sig_in=0 -> locked, strobes, period_out and err_count all 0; state IDLE.
- Lock: pulses at cycles 2,13,24,35 -> pulse_ok high at 14,25,36; period_out=11; locked=1 from cycle 36.
- Tolerance: while locked, gaps 10, 12, 9 -> pulse_ok, pulse_ok, then early_err; period_out=9; locked drops the following cycle; next 3 gaps of 11 -> locked again.
- Missing pulse: locked, last pulse at cycle t, sig_in stays 0 -> late_err high only at t+14; locked=0 from t+14; state IDLE; no further late_err strobes.
- Held level: sig_in high for 5 cycles, then pulses every 11 cycles measured from the first rising edge -> each high run counts as one edge; behaves as the Lock scenario.
- Stats (macro defined): 300 early pulses -> err_count=255, no wrap; macro undefined -> err_count stays 0.
